// File: rtl/cake_drop_scheduler.sv
// Frame sequencer for the falling-object game: spawns cakes/cherry, steps them down,
// tests them against the plate and offers at most one caught item per frame to the sidebar.
module cake_drop_scheduler #(
  parameter int CAKE_W    = 9,
  parameter int CAKE_H    = 6,
  parameter int CHERRY_W  = 13,
  parameter int CHERRY_H  = 14,
  parameter int FLOOR_Y   = 119,
  parameter int SPAWN_GAP = 20,
  parameter int STACK_MAX = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [7:0]  plate_x,
  input  logic [6:0]  plate_y,
  // "rand" is a reserved word in SystemVerilog, hence rand_val
  input  logic [7:0]  rand_val,
  input  logic        push_ready,
  output logic [31:0] obj_x,
  output logic [27:0] obj_y,
  output logic [11:0] obj_clr,
  output logic [3:0]  obj_active,
  output logic        push_valid,
  output logic [2:0]  push_clr,
  output logic        push_cherry,
  output logic [2:0]  layer_count,
  output logic        round_done,
  output logic        busy,
  output logic        frame_overrun
);

  localparam logic [7:0] CAKE_W8   = 8'(CAKE_W);
  localparam logic [7:0] CAKE_H8   = 8'(CAKE_H);
  localparam logic [7:0] CHERRY_W8 = 8'(CHERRY_W);
  localparam logic [7:0] CHERRY_H8 = 8'(CHERRY_H);
  localparam logic [7:0] FLOOR8    = 8'(FLOOR_Y);
  localparam logic [7:0] GAP8      = 8'(SPAWN_GAP);
  localparam logic [2:0] FULL_LC   = 3'(STACK_MAX);

  typedef enum logic [2:0] {IDLE, SPAWN, MOVE, CHECK, PUSH} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [7:0]  gap_cnt;
  logic [7:0]  sx [4];
  logic [6:0]  sy [4];
  logic [2:0]  sc [4];
  logic        lat_vld, lat_cherry;
  logic [2:0]  lat_clr;

  logic        free_ok, sp_cherry, hit, push_go, miss;
  logic [1:0]  free_idx;
  logic [2:0]  sp_clr;
  logic [7:0]  h_sel, w_sel, ck_sum, mv_sum, x_hi;
  logic [8:0]  x_hi9;
  logic [6:0]  ny;
  logic        unused_rand;

  assign unused_rand = rand_val[7];

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign obj_x[8*g +: 8]   = sx[g];
    assign obj_y[7*g +: 7]   = sy[g];
    assign obj_clr[3*g +: 3] = sc[g];
  end

  always_comb begin
    free_ok  = 1'b0;
    free_idx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (!obj_active[i]) begin
        free_ok  = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_comb begin
    sp_cherry = (layer_count == FULL_LC) && !obj_active[3];
    sp_clr    = (rand_val[2:0] == 3'b000) ? 3'b001 : rand_val[2:0];
    h_sel     = (idx == 2'd3) ? CHERRY_H8 : CAKE_H8;
    w_sel     = (idx == 2'd3) ? CHERRY_W8 : CAKE_W8;
    ny        = sy[idx] + 7'd1;
    mv_sum    = {1'b0, ny} + h_sel;
    miss      = mv_sum > FLOOR8;
    ck_sum    = {1'b0, sy[idx]} + h_sel;
    // right edge of the catch window clamps at the screen edge instead of wrapping
    x_hi9     = {1'b0, sx[idx]} + {1'b0, w_sel} - 9'd1;
    x_hi      = x_hi9[8] ? 8'hFF : x_hi9[7:0];
    hit       = obj_active[idx] && (ck_sum == {1'b0, plate_y}) &&
                (plate_x >= sx[idx]) && (plate_x <= x_hi);
    push_go   = lat_vld && (lat_cherry || (layer_count != FULL_LC));
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (frame_tick && !round_done) state_nxt = SPAWN;
      SPAWN: state_nxt = MOVE;
      MOVE:  if (idx == 2'd3) state_nxt = CHECK;
      CHECK: if (idx == 2'd3) state_nxt = PUSH;
      PUSH: begin
        if (!push_valid) begin
          if (!push_go) state_nxt = IDLE;
        end else if (push_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
      idx           <= 2'd0;
      gap_cnt       <= 8'd0;
      obj_active    <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        sx[i] <= 8'd0;
        sy[i] <= 7'd0;
        sc[i] <= 3'd0;
      end
      lat_vld     <= 1'b0;
      lat_cherry  <= 1'b0;
      lat_clr     <= 3'd0;
      push_valid  <= 1'b0;
      push_clr    <= 3'd0;
      push_cherry <= 1'b0;
      layer_count <= 3'd0;
      round_done  <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (frame_tick && (state != IDLE)) frame_overrun <= 1'b1;
      case (state)
        SPAWN: begin
          idx     <= 2'd0;
          lat_vld <= 1'b0;
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (sp_cherry) begin
            sx[3]         <= {1'b0, rand_val[6:0]};
            sy[3]         <= 7'd0;
            sc[3]         <= 3'b111;
            obj_active[3] <= 1'b1;
            gap_cnt       <= GAP8;
          end else if (free_ok) begin
            sx[free_idx]         <= {1'b0, rand_val[6:0]};
            sy[free_idx]         <= 7'd0;
            sc[free_idx]         <= sp_clr;
            obj_active[free_idx] <= 1'b1;
            gap_cnt              <= GAP8;
          end
        end
        MOVE: begin
          idx <= idx + 2'd1;
          if (obj_active[idx]) begin
            sy[idx] <= ny;
            if (miss) obj_active[idx] <= 1'b0;
          end
        end
        CHECK: begin
          idx <= idx + 2'd1;
          // only the highest-priority catch is taken; later ones fall on
          if (hit && !lat_vld) begin
            lat_vld          <= 1'b1;
            lat_clr          <= sc[idx];
            lat_cherry       <= (idx == 2'd3);
            obj_active[idx]  <= 1'b0;
          end
        end
        PUSH: begin
          if (!push_valid) begin
            if (push_go) begin
              push_valid  <= 1'b1;
              push_clr    <= lat_clr;
              push_cherry <= lat_cherry;
            end
          end else if (push_ready) begin
            push_valid <= 1'b0;
            if (push_cherry) round_done  <= 1'b1;
            else             layer_count <= layer_count + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cake_drop_scheduler.sv
// Randomized scoreboard bench for cake_drop_scheduler against a frame-level reference model.
module tb_cake_drop_scheduler;
  localparam int CW = 9, CH = 6, HW = 13, HH = 14, FL = 119, GAP = 20, SMAX = 6;

  logic        clock = 1'b0;
  logic        reset, frame_tick, push_ready;
  logic [7:0]  plate_x, rand_val;
  logic [6:0]  plate_y;
  logic [31:0] obj_x;
  logic [27:0] obj_y;
  logic [11:0] obj_clr;
  logic [3:0]  obj_active;
  logic        push_valid, push_cherry, round_done, busy, frame_overrun;
  logic [2:0]  push_clr, layer_count;

  cake_drop_scheduler dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .plate_x(plate_x), .plate_y(plate_y), .rand_val(rand_val),
    .push_ready(push_ready), .obj_x(obj_x), .obj_y(obj_y), .obj_clr(obj_clr),
    .obj_active(obj_active), .push_valid(push_valid), .push_clr(push_clr),
    .push_cherry(push_cherry), .layer_count(layer_count), .round_done(round_done),
    .busy(busy), .frame_overrun(frame_overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] x;
    logic [27:0] y;
    logic [11:0] c;
    logic [3:0]  a;
    logic [2:0]  lc;
    logic        rd;
    logic        ov;
  } snap_t;

  typedef struct packed {
    logic [2:0] clr;
    logic       ch;
  } item_t;

  int checks = 0, failures = 0;
  item_t pq[$];
  snap_t sq[$];

  int mx[4], my[4], mc[4];
  bit ma[4];
  int gap, layers;
  bit done, ov;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int hgt(input int i);
    return (i == 3) ? HH : CH;
  endfunction

  function automatic int wid(input int i);
    return (i == 3) ? HW : CW;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0; my[i] = 0; mc[i] = 0; ma[i] = 0;
    end
    gap = 0; layers = 0; done = 0; ov = 0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s.x[8*i +: 8] = 8'(mx[i]);
      s.y[7*i +: 7] = 7'(my[i]);
      s.c[3*i +: 3] = 3'(mc[i]);
      s.a[i] = ma[i];
    end
    s.lc = 3'(layers);
    s.rd = done;
    s.ov = ov;
    return s;
  endfunction

  // One whole frame of game rules: spawn, fall, catch, hand-off.
  task automatic model_frame(input int r, input int px, input int py, output bit hp, output item_t it);
    int s, hi;
    bit found;
    hp = 0; it = '0; found = 0;
    if (gap != 0) gap--;
    else if (layers == SMAX && !ma[3]) begin
      mx[3] = r % 128; my[3] = 0; mc[3] = 7; ma[3] = 1; gap = GAP;
    end else begin
      s = -1;
      for (int i = 2; i >= 0; i--) if (!ma[i]) s = i;
      if (s >= 0) begin
        mx[s] = r % 128; my[s] = 0; mc[s] = (r % 8 == 0) ? 1 : r % 8; ma[s] = 1; gap = GAP;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ma[i]) begin
        my[i]++;
        if (my[i] + hgt(i) > FL) ma[i] = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ma[i] && my[i] + hgt(i) == py) begin
        hi = mx[i] + wid(i) - 1;
        if (hi > 255) hi = 255;
        if (px >= mx[i] && px <= hi && !found) begin
          found = 1; it.clr = 3'(mc[i]); it.ch = (i == 3); ma[i] = 0;
        end
      end
    end
    if (found) begin
      if (it.ch) begin hp = 1; done = 1; end
      else if (layers < SMAX) begin hp = 1; layers++; end
    end
  endtask

  task automatic pick_plate(input bit aim, input bit exact, output logic [7:0] px, output logic [6:0] py);
    int j, k;
    px = 8'($urandom_range(0, 255));
    py = 7'($urandom_range(0, 127));
    if (aim) begin
      j = -1;
      for (int i = 0; i < 4; i++)
        if (ma[i] && my[i] + 1 + hgt(i) <= FL && (j < 0 || i == 3 || $urandom_range(0, 1) == 1)) j = i;
      if (j >= 0) begin
        py = 7'(my[j] + 1 + hgt(j));
        k = exact ? 7 : int'($urandom_range(0, 7));
        if (k == 0 && mx[j] > 0) px = 8'(mx[j] - 1);
        else if (k == 1) px = 8'(mx[j] + wid(j));
        else px = 8'(mx[j] + int'($urandom_range(0, wid(j) - 1)));
      end
    end
  endtask

  // Monitor: scores every offered push and every frame-end state against the queues.
  bit busy_prev = 0;
  snap_t e;
  always @(negedge clock) begin
    if (!reset) begin
      if (push_valid) begin
        if (pq.size() == 0) chk("push_unexpected", push_valid, 0);
        else begin
          chk("push_clr", push_clr, pq[0].clr);
          chk("push_cherry", push_cherry, pq[0].ch);
          if (push_ready) void'(pq.pop_front());
        end
      end
      if (busy_prev && !busy) begin
        if (sq.size() == 0) chk("frame_end_unexpected", sq.size(), 1);
        else begin
          e = sq.pop_front();
          chk("obj_x", obj_x, e.x);
          chk("obj_y", obj_y, e.y);
          chk("obj_clr", obj_clr, e.c);
          chk("obj_active", obj_active, e.a);
          chk("layer_count", layer_count, e.lc);
          chk("round_done", round_done, e.rd);
          chk("frame_overrun", frame_overrun, e.ov);
        end
      end
    end
    busy_prev = busy;
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; frame_tick = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    pq.delete(); sq.delete();
    model_init();
  endtask

  task automatic reset_checks();
    @(negedge clock);
    chk("rst_obj_x", obj_x, 0);
    chk("rst_obj_y", obj_y, 0);
    chk("rst_obj_clr", obj_clr, 0);
    chk("rst_obj_active", obj_active, 0);
    chk("rst_push_valid", push_valid, 0);
    chk("rst_push_clr", push_clr, 0);
    chk("rst_push_cherry", push_cherry, 0);
    chk("rst_layer_count", layer_count, 0);
    chk("rst_round_done", round_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_overrun", frame_overrun, 0);
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready low for the first 12 cycles
  task automatic run_frame(input logic [7:0] r, input logic [7:0] px, input logic [6:0] py,
                           input int mode, input bit inj);
    bit hp, was_done, fin;
    item_t it;
    int cnt;
    was_done = done;
    hp = 0;
    if (!was_done) begin
      model_frame(int'(r), int'(px), int'(py), hp, it);
      if (hp) pq.push_back(it);
      if (inj) ov = 1;
      sq.push_back(model_snap());
    end
    @(posedge clock); #1;
    plate_x = px; plate_y = py; rand_val = r;
    push_ready = (mode != 2); frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    if (was_done) begin
      repeat (3) begin
        @(negedge clock);
        chk("busy_after_round", busy, 0);
      end
      chk("overrun_after_round", frame_overrun, ov);
    end else begin
      cnt = 0; fin = 0;
      for (int c = 0; c < 300 && !fin; c++) begin
        @(negedge clock);
        if (!busy) fin = 1;
        else begin
          cnt++;
          @(posedge clock); #1;
          case (mode)
            0: push_ready = 1'b1;
            1: push_ready = 1'($urandom_range(0, 1));
            default: push_ready = (c >= 12);
          endcase
          frame_tick = inj && (c == 2);
        end
      end
      frame_tick = 1'b0;
      chk("frame_end_seen", fin, 1);
      if (mode == 0) chk("busy_cycles", cnt, hp ? 11 : 10);
      chk("push_queue_drained", pq.size(), 0);
    end
  endtask

  initial begin
    logic [7:0] px;
    logic [6:0] py;
    bit hp;
    item_t it;
    reset = 1'b1; frame_tick = 1'b0; push_ready = 1'b0;
    plate_x = 8'd0; plate_y = 7'd0; rand_val = 8'd0;
    model_init();
    do_reset();
    reset_checks();

    run_frame(8'h35, 8'd0, 7'd0, 0, 0);

    for (int f = 0; f < 500 && !done; f++) begin
      pick_plate($urandom_range(0, 9) < 7, 0, px, py);
      run_frame(8'($urandom_range(0, 255)), px, py, int'($urandom_range(0, 2)),
                $urandom_range(0, 7) == 0);
    end
    chk("round_done_reached", round_done, done);
    for (int f = 0; f < 3; f++) run_frame(8'($urandom_range(0, 255)), 8'd0, 7'd0, 0, 0);

    do_reset();
    reset_checks();
    run_frame(8'($urandom_range(0, 255)), 8'd0, 7'd0, 0, 0);

    // stall a guaranteed catch, then reset while the push is outstanding
    pick_plate(1, 1, px, py);
    model_frame(int'(rand_val), int'(px), int'(py), hp, it);
    chk("stall_push_expected", hp, 1);
    if (hp) pq.push_back(it);
    sq.push_back(model_snap());
    @(posedge clock); #1;
    plate_x = px; plate_y = py; push_ready = 1'b0; frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    chk("stall_push_valid", push_valid, 1);
    chk("stall_busy", busy, 1);
    chk("stall_layer_count", layer_count, 0);
    @(posedge clock); #1;
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    @(negedge clock);
    chk("stall_overrun", frame_overrun, 1);
    chk("stall_push_still_valid", push_valid, 1);
    do_reset();
    reset_checks();

    for (int f = 0; f < 30; f++) begin
      pick_plate($urandom_range(0, 1) == 1, 0, px, py);
      run_frame(8'($urandom_range(0, 255)), px, py, int'($urandom_range(0, 2)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
